align_shr: RTL and testbench
============================

# align_shr

Multi-cycle right-shift alignment unit for the BFloat16 datapath: the counterpart of the leading-zero-count normaliser, it inserts leading zeros rather than measuring them. It takes a mantissa (hidden bit included) and an exponent difference, shifts the mantissa right one power-of-two stage per cycle, and returns the aligned mantissa with guard, round and sticky bits. Sits between exponent compare and the mantissa adder; valid/ready handshakes on both sides.

## Interface
- `W`, default 8: mantissa width including hidden bit.
- `E_W`, default 8: shift-amount width (exponent difference).
- `L`, localparam `$clog2(W+3)`: number of shift stages; 4 for W=8.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `valid_i`  in  1  input operand valid.
- `ready_o`  out  1  unit can accept an operand this cycle.
- `data_i`  in  W  mantissa to align.
- `shamt_i`  in  E_W  unsigned right-shift amount.
- `valid_o`  out  1  result valid.
- `ready_i`  in  1  consumer accepts result.
- `data_o`  out  W  aligned mantissa.
- `guard_o`  out  1  first bit shifted out below the mantissa LSB.
- `round_o`  out  1  second bit shifted out.
- `sticky_o`  out  1  OR of every bit shifted out beyond the round position.

## Operation
- Working register `acc` is W+2 bits, `{mant, g, r}`, plus a 1-bit `stk` and an L-bit shift register `sh`.
- Clamp: `sh = (shamt_i >= W+2) ? W+2 : shamt_i[L-1:0]`. Shifting by W+2 moves every bit into sticky; larger shifts give the same result.
- Load on accept: `acc = {data_i, 2'b00}`, `stk = 0`, step counter `k = 0`.
- Stage k, one per cycle: if `sh[k]`, then `stk |= |acc[2^k-1:0]` and `acc >>= 2^k`. Otherwise acc is unchanged. Every stage takes its cycle; latency is fixed and independent of the shift amount.
- Outputs: `data_o = acc[W+1:2]`, `guard_o = acc[1]`, `round_o = acc[0]`, `sticky_o = stk`.
- FSM states and transitions:
  - IDLE: `ready_o = 1`. On `valid_i`, load and go to SHIFT.
  - SHIFT: `ready_o = 0`, `valid_o = 0`. Apply stage k. When `k == L-1`, go to DONE; otherwise `k++`.
  - DONE: `valid_o = 1`, outputs stable.
    - On `ready_i & valid_i`: hand over the result and load the new operand in the same cycle, going to SHIFT.
    - On `ready_i` only: go to IDLE.
    - With `!ready_i`: hold.
- `ready_o = IDLE | (DONE & ready_i)`. This is combinational on `ready_i`.
- When `valid_o = 0`, the outputs carry the current acc contents and are don't-care for the consumer.

## Timing
- Reset forces, on the next edge, whatever the current state:
  - state IDLE, `k = 0`, acc = 0, stk = 0;
  - `valid_o = 0`, `ready_o = 1`;
  - `data_o`, `guard_o`, `round_o`, `sticky_o` all 0.
- A reset asserted during SHIFT or DONE discards the in-flight operand; no result is produced for it.
- Latency: an operand accepted at edge 0 updates in SHIFT at edges 1..L. `valid_o` is high after edge L (edge 4 for W=8).
- Throughput with `ready_i` held high: one result every L+1 cycles (5 for W=8). There is no idle bubble between operations.
- Backpressure: while `valid_o & !ready_i`, all outputs are held constant and `ready_o = 0`.
- `valid_i` asserted while `ready_o = 0` is ignored. The upstream block holds its data until a handshake occurs.

## Test plan
All scenarios use W=8, E_W=8.
- Reset, then `data_i = 0x81`, `shamt_i = 3` -> `valid_o` rises 4 cycles after accept with `data_o = 0x10`, g=0, r=0, s=1.
- `0xFF`, shamt 2 -> `0x3F`, g=1, r=1, s=0.
- `0xA5`, shamt 0 -> `0xA5`, g=r=s=0.
- Clamp and exact-width boundaries:
  - `0x80`, shamt 200 -> `0x00`, g=0, r=0, s=1.
  - `0x00`, shamt 255 -> all outputs 0.
  - `0x80`, shamt 9 -> `0x00`, g=0, r=1, s=0.
  - `0x80`, shamt 10 -> `0x00`, g=r=0, s=1.
- Backpressure and back-to-back operation:
  - Hold `ready_i = 0` for 3 cycles in DONE -> outputs stable and `ready_o = 0`.
  - Then assert `ready_i` with the next operand valid -> the new operand is accepted in the same cycle, and its result appears 4 cycles later.
- Assert reset in the second SHIFT cycle -> `valid_o` stays 0, `ready_o = 1` after the reset edge, and no stale result is emitted afterwards.

Source files
------------

// File: rtl/align_shr.sv
// -----------------------------------------------------------------------------
// align_shr
//
// Multi-cycle right-shift alignment unit for the BFloat16 datapath. An
// operand mantissa (hidden bit included) is shifted right by an exponent
// difference, one power-of-two stage per clock, producing the aligned
// mantissa plus guard, round and sticky bits for the following adder.
// The latency is fixed at L shift cycles whatever the shift amount, which
// keeps the downstream pipeline timing independent of the data.
//
// Parameters
//   W    mantissa width including the hidden bit
//   E_W  width of the shift amount (exponent difference)
//
// Ports
//   clk       in   clock, all state changes on the rising edge
//   reset     in   synchronous active-high reset
//   valid_i   in   input operand valid
//   ready_o   out  unit accepts an operand this cycle (combinational on ready_i)
//   data_i    in   [W-1:0]   mantissa to align
//   shamt_i   in   [E_W-1:0] unsigned right-shift amount
//   valid_o   out  result valid
//   ready_i   in   consumer accepts the result
//   data_o    out  [W-1:0]   aligned mantissa
//   guard_o   out  first bit shifted out below the mantissa LSB
//   round_o   out  second bit shifted out
//   sticky_o  out  OR of every bit shifted out beyond the round position
// -----------------------------------------------------------------------------
module align_shr #(
   parameter int W   = 8,
   parameter int E_W = 8
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           valid_i,
   output logic           ready_o,
   input  logic [W-1:0]   data_i,
   input  logic [E_W-1:0] shamt_i,
   output logic           valid_o,
   input  logic           ready_i,
   output logic [W-1:0]   data_o,
   output logic           guard_o,
   output logic           round_o,
   output logic           sticky_o
);

   // Working width: mantissa followed by guard and round positions.
   localparam int AW  = W + 2;
   // Number of shift stages; the stage amounts 1,2,4,.. sum to at least AW.
   localparam int L   = $clog2(W + 3);
   // Width of the stage counter.
   localparam int K_W = (L > 1) ? $clog2(L) : 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SHIFT = 2'd1;
   localparam logic [1:0] ST_DONE  = 2'd2;

   logic [1:0]     state_q, state_d;
   logic [K_W-1:0] k_q,     k_d;
   logic [L-1:0]   sh_q,    sh_d;
   logic [AW-1:0]  acc_q,   acc_d;
   logic           stk_q,   stk_d;

   logic [L-1:0]   sh_load;
   logic           load_en;
   logic           last_stage;

   // Per-stage candidate results: acc shifted by 2^gi and the OR of the
   // bits that shift would discard. Only the stage selected by k is used.
   logic [AW-1:0]  stage_acc [L];
   logic [L-1:0]   stage_stk;

   genvar gi;
   generate
      for (gi = 0; gi < L; gi++) begin : g_stage
         localparam int STEP = 1 << gi;
         // A stage can never discard more bits than acc holds.
         localparam int NLOW = (STEP > AW) ? AW : STEP;
         assign stage_acc[gi] = acc_q >> STEP;
         assign stage_stk[gi] = |acc_q[NLOW-1:0];
      end
   endgenerate

   // Any shift of AW or more empties acc into sticky, so it is clamped to
   // AW; the clamped value always fits in L bits.
   always_comb begin
      sh_load = shamt_i[L-1:0];
      if (int'(shamt_i) >= AW) begin
         sh_load = L'(AW);
      end
   end

   assign last_stage = (k_q == K_W'(L - 1));

   // Handshake outputs. ready_o looks through DONE at ready_i so a new
   // operand can be taken in the same cycle the result is handed over.
   assign valid_o = (state_q == ST_DONE);
   assign ready_o = (state_q == ST_IDLE) | ((state_q == ST_DONE) & ready_i);

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      sh_d    = sh_q;
      acc_d   = acc_q;
      stk_d   = stk_q;
      load_en = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (valid_i) begin
               load_en = 1'b1;
            end
         end

         ST_SHIFT: begin
            // Every stage consumes its cycle even when its bit of the
            // shift amount is clear, giving a data-independent latency.
            if (sh_q[k_q]) begin
               acc_d = stage_acc[k_q];
               stk_d = stk_q | stage_stk[k_q];
            end
            if (last_stage) begin
               state_d = ST_DONE;
               k_d     = '0;
            end else begin
               k_d     = k_q + K_W'(1);
            end
         end

         ST_DONE: begin
            if (ready_i) begin
               if (valid_i) begin
                  load_en = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
            k_d     = '0;
         end
      endcase

      if (load_en) begin
         state_d = ST_SHIFT;
         k_d     = '0;
         sh_d    = sh_load;
         acc_d   = {data_i, 2'b00};
         stk_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         k_q     <= '0;
         sh_q    <= '0;
         acc_q   <= '0;
         stk_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         sh_q    <= sh_d;
         acc_q   <= acc_d;
         stk_q   <= stk_d;
      end
   end

   // Result fields come straight from the working registers; outside DONE
   // they show the in-flight value and are ignored by the consumer.
   assign data_o   = acc_q[AW-1:2];
   assign guard_o  = acc_q[1];
   assign round_o  = acc_q[0];
   assign sticky_o = stk_q;

endmodule

// File: tb/tb_align_shr.sv
module tb_align_shr;

   logic       clk = 1'b0;
   logic       reset;
   logic       valid_i;
   logic       ready_o;
   logic [7:0] data_i;
   logic [7:0] shamt_i;
   logic       valid_o;
   logic       ready_i;
   logic [7:0] data_o;
   logic       guard_o;
   logic       round_o;
   logic       sticky_o;

   always #5 clk = ~clk;

   align_shr #(.W(8), .E_W(8)) dut (
      .clk      (clk),
      .reset    (reset),
      .valid_i  (valid_i),
      .ready_o  (ready_o),
      .data_i   (data_i),
      .shamt_i  (shamt_i),
      .valid_o  (valid_o),
      .ready_i  (ready_i),
      .data_o   (data_o),
      .guard_o  (guard_o),
      .round_o  (round_o),
      .sticky_o (sticky_o)
   );

   typedef struct {
      logic [7:0]  d;
      logic [7:0]  s;
      logic [10:0] exp;
   } txn_t;

   txn_t sb[$];
   int   checks = 0;
   int   errors = 0;
   bit   rand_mode = 0;

   // Reference: the whole {mant,g,r} word shifted by the clamped amount;
   // sticky is whether any set bit fell off the bottom.
   function automatic logic [10:0] model(input logic [7:0] d, input logic [7:0] s);
      logic [63:0] full;
      logic [63:0] res;
      logic [63:0] lost;
      int          n;
      full = {54'd0, d, 2'b00};
      n    = (s >= 8'd10) ? 10 : int'(s);
      res  = full >> n;
      lost = full & ((64'd1 << n) - 64'd1);
      return {res[9:0], (lost != 64'd0)};
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   // Advance to just after the next rising edge; in random mode also
   // re-roll the consumer's ready.
   task automatic tick();
      @(posedge clk);
      #1;
      if (rand_mode) ready_i = ($urandom_range(0, 3) != 0);
   endtask

   // Present one operand (called just after a rising edge). Pushes the
   // expected result when the handshake is seen, returns cycles waited,
   // and optionally measures the edges until valid_o.
   task automatic send(input logic [7:0] d, input logic [7:0] s,
                       input bit lat_chk, output int waits);
      txn_t t;
      int   n;
      bit   got_it;
      valid_i = 1'b1;
      data_i  = d;
      shamt_i = s;
      waits   = 0;
      got_it  = 0;
      while (!got_it) begin
         @(negedge clk);
         if (ready_o) begin
            t.d = d; t.s = s; t.exp = model(d, s);
            sb.push_back(t);
            got_it = 1;
            tick();
            valid_i = 1'b0;
         end else begin
            waits++;
            if (waits > 200) begin
               chk("accept_timeout", 32'(waits), 32'd0);
               valid_i = 1'b0;
               return;
            end
            tick();
         end
      end
      if (lat_chk) begin
         n = 0;
         forever begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (valid_o || n > 30) break;
         end
         chk("latency", 32'(n), 32'd4);
         tick();
      end
   endtask

   // Monitor: pops and compares whenever a result is handed over.
   initial begin
      txn_t        t;
      logic [10:0] got;
      forever begin
         @(negedge clk);
         if (!reset && valid_o) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL stale_result got=%0h exp=none",
                        {data_o, guard_o, round_o, sticky_o});
            end else if (ready_i) begin
               t   = sb.pop_front();
               got = {data_o, guard_o, round_o, sticky_o};
               checks++;
               if (got !== t.exp) begin
                  errors++;
                  $display("FAIL result d=%02h sh=%0d got=%03h exp=%03h", t.d, t.s, got, t.exp);
               end else begin
                  $display("txn d=%02h sh=%0d data=%02h g=%0b r=%0b s=%0b ok",
                           t.d, t.s, data_o, guard_o, round_o, sticky_o);
               end
            end
         end
      end
   end

   logic [7:0] dir_d [7] = '{8'h81, 8'hFF, 8'hA5, 8'h80, 8'h00, 8'h80, 8'h80};
   logic [7:0] dir_s [7] = '{8'd3,  8'd2,  8'd0,  8'd200, 8'd255, 8'd9, 8'd10};

   initial begin
      int          w;
      int          n;
      logic [10:0] hold;
      logic [7:0]  rd;
      logic [7:0]  rs;

      reset   = 1'b1;
      valid_i = 1'b0;
      ready_i = 1'b0;
      data_i  = '0;
      shamt_i = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("reset_valid_o", 32'(valid_o), 32'd0);
      chk("reset_ready_o", 32'(ready_o), 32'd1);
      chk("reset_outputs", 32'({data_o, guard_o, round_o, sticky_o}), 32'd0);
      tick();

      // Directed operands, including the clamp and exact-width cases.
      ready_i = 1'b1;
      for (int i = 0; i < 7; i++) begin
         send(dir_d[i], dir_s[i], 1, w);
      end

      // Backpressure: result must hold with ready_o low.
      ready_i = 1'b0;
      send(8'hC3, 8'd5, 0, w);
      n = 0;
      forever begin
         @(negedge clk);
         n++;
         if (valid_o || n > 20) break;
      end
      chk("bp_valid_rises", 32'(valid_o), 32'd1);
      hold = {data_o, guard_o, round_o, sticky_o};
      for (int i = 0; i < 3; i++) begin
         tick();
         @(negedge clk);
         chk("bp_hold_outputs", 32'({data_o, guard_o, round_o, sticky_o}), 32'(hold));
         chk("bp_ready_o_low", 32'(ready_o), 32'd0);
         chk("bp_valid_held", 32'(valid_o), 32'd1);
      end
      tick();
      // Release with a new operand waiting: accepted at the handover.
      ready_i = 1'b1;
      send(8'h9B, 8'd4, 1, w);
      chk("same_cycle_accept", 32'(w), 32'd0);

      // Reset in the second SHIFT cycle drops the operand.
      send(8'h5A, 8'd7, 0, w);
      tick();
      reset = 1'b1;
      sb.delete();
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("midreset_valid_o", 32'(valid_o), 32'd0);
      chk("midreset_ready_o", 32'(ready_o), 32'd1);
      chk("midreset_outputs", 32'({data_o, guard_o, round_o, sticky_o}), 32'd0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("midreset_no_result", 32'(valid_o), 32'd0);
      end
      tick();

      // Randomized traffic with random consumer backpressure.
      rand_mode = 1;
      for (int i = 0; i < 300; i++) begin
         rd = 8'($urandom);
         if ($urandom_range(0, 3) == 0) rs = 8'($urandom_range(0, 255));
         else                           rs = 8'($urandom_range(0, 11));
         repeat ($urandom_range(0, 2)) tick();
         send(rd, rs, 0, w);
      end
      rand_mode = 0;
      ready_i   = 1'b1;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("drain_empty", 32'(sb.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
